// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: SP_src codes, FSM states, access widths.
// Pure declarations, no logic and no latency.
// No flow control of its own; consumers sequence against these codes.
package mem_pkg;

    // SP_src_in encodings; code 3 is deliberately unnamed and behaves like SP_NONE.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_PUSH = 2'd1,
        SP_POP  = 2'd2
    } sp_src_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } fsm_state_t;

    // mem_type_in encodings.
    typedef enum logic {
        MEM_T16 = 1'b0,
        MEM_T32 = 1'b1
    } mem_type_t;

endpackage

// File: rtl/stack_pointer.sv
// Stack-pointer register for the memory stage, stepping by one or two words per access.
// SP updates on the clock edge that closes the access; guard compare is combinational.
// No flow control: the owner asserts at most one step control per cycle.
// Optional feature macro: STACK_GUARD_EN (adds guard_hit and sticky stack_exc).
// Ports: clk, reset (async, active-high), inc1/inc2/dec1/dec2 step controls, sp value;
//        with the guard: chk_push/chk_pop/chk_two request, guard_hit, stack_exc.
module stack_pointer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = 12'hFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc1,
    input  logic              inc2,
    input  logic              dec1,
    input  logic              dec2,
    output logic [ADDR_W-1:0] sp
`ifdef STACK_GUARD_EN
    ,
    input  logic              chk_push,
    input  logic              chk_pop,
    input  logic              chk_two,
    output logic              guard_hit,
    output logic              stack_exc
`endif
);

    logic [ADDR_W-1:0] sp_nxt;

    always_comb begin
        sp_nxt = sp;
        if (dec1)      sp_nxt = sp - ADDR_W'(1);
        else if (dec2) sp_nxt = sp - ADDR_W'(2);
        else if (inc1) sp_nxt = sp + ADDR_W'(1);
        else if (inc2) sp_nxt = sp + ADDR_W'(2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sp <= SP_RESET;
        else       sp <= sp_nxt;
    end

`ifdef STACK_GUARD_EN
    // One extra bit so neither direction can wrap inside the compare.
    logic [ADDR_W:0] step_w;
    logic [ADDR_W:0] sp_w;

    assign step_w = chk_two ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    assign sp_w   = {1'b0, sp};

    always_comb begin
        guard_hit = 1'b0;
        if (chk_push && (sp_w < step_w))                      guard_hit = 1'b1;
        if (chk_pop && ((sp_w + step_w) > {1'b0, SP_RESET}))  guard_hit = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          stack_exc <= 1'b0;
        else if (guard_hit) stack_exc <= 1'b1;
    end
`endif

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: owns SP and sequences 16-bit data-memory beats (32-bit accesses take two).
// 16-bit access completes in one cycle; 32-bit access takes two (IDLE, BEAT2).
// Backpressure: stall_out is high in the first beat of a 32-bit access to freeze upstream.
// Optional feature macro: STACK_GUARD_EN (adds stack_exc_out, suppresses over/underflow).
// Ports: EX/MEM controls and data in; dmem_* async-read memory interface; mem_data_out,
//        Rdst2_val_out to MEM/WB; popped flags/PC back to execute/fetch; stall_out; SP_out.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = 12'hFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_type_in,
    input  logic [1:0]        SP_src_in,
    input  logic              mem_addr_src_in,
    input  logic              mem_data_src_in,
    input  logic              PC_push_pop_in,
    input  logic              flags_push_pop_in,
    input  logic              INT_in,
    input  logic [31:0]       PC_in,
    input  logic [15:0]       Rdst1_val_in,
    input  logic [15:0]       Rdst2_val_in,
    input  logic [15:0]       Rdst_val_in,
    input  logic [15:0]       dmem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       Rdst2_val_out,
    output logic [3:0]        POP_flags_val_out,
    output logic              is_POP_flags_out,
    output logic [31:0]       pop_pc_out,
    output logic              do_pop_pc_out,
    output logic              stall_out,
    output logic [ADDR_W-1:0] SP_out
`ifdef STACK_GUARD_EN
    ,
    output logic              stack_exc_out
`endif
);

    fsm_state_t        state, state_nxt;
    logic [ADDR_W-1:0] sp;
    logic [15:0]       lo_q;

    logic              wr, rd, active, is32, is_push, is_pop, go, guard_hit;
    logic [1:0]        sp_op;
    logic [31:0]       data32;
    logic [15:0]       data16;
    logic [ADDR_W-1:0] base;
    logic              sp_inc1, sp_inc2, sp_dec1, sp_dec2;

    // Address bits above ADDR_W are not part of the data-memory space.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^Rdst1_val_in[15:ADDR_W];

    // Decode. An interrupt is a write, a push and 32 bits wide regardless of the other
    // controls; a write with a simultaneous read drops the read.
    assign wr      = mem_write_in | INT_in;
    assign rd      = mem_read_in & ~wr;
    assign active  = wr | rd;
    assign is32    = (mem_type_in == MEM_T32) | PC_push_pop_in | INT_in;
    assign sp_op   = INT_in ? SP_PUSH : SP_src_in;
    assign is_push = wr & (sp_op == SP_PUSH);
    assign is_pop  = rd & (sp_op == SP_POP);

    // 32-bit data from Rdst carries the ALU high word in Rdst2.
    assign data32  = (INT_in | mem_data_src_in) ? PC_in : {Rdst2_val_in, Rdst_val_in};
    assign data16  = mem_data_src_in ? PC_in[15:0] : Rdst_val_in;

    // First-beat address. Pops pre-increment because SP points at the next free slot.
    always_comb begin
        base = Rdst1_val_in[ADDR_W-1:0];
        if (is_pop)                          base = sp + ADDR_W'(1);
        else if (is_push || mem_addr_src_in) base = sp;
    end

    assign Rdst2_val_out = Rdst2_val_in;
    assign SP_out        = sp;

    stack_pointer #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk       (clk),
        .reset     (reset),
        .inc1      (sp_inc1),
        .inc2      (sp_inc2),
        .dec1      (sp_dec1),
        .dec2      (sp_dec2),
        .sp        (sp)
`ifdef STACK_GUARD_EN
        ,
        .chk_push  ((state == IDLE) & is_push),
        .chk_pop   ((state == IDLE) & is_pop),
        .chk_two   (is32),
        .guard_hit (guard_hit),
        .stack_exc (stack_exc_out)
`endif
    );

`ifndef STACK_GUARD_EN
    assign guard_hit = 1'b0;
`endif

    // A guarded access is dropped outright: no beat, no stall, no SP step.
    assign go = active & ~guard_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            // Low half of a 32-bit read is held until the high half arrives.
            if (state == IDLE && go && is32 && rd) lo_q <= dmem_rdata;
        end
    end

    always_comb begin
        state_nxt         = state;
        stall_out         = 1'b0;
        dmem_addr         = '0;
        dmem_wdata        = '0;
        dmem_we           = 1'b0;
        dmem_re           = 1'b0;
        mem_data_out      = '0;
        is_POP_flags_out  = 1'b0;
        POP_flags_val_out = '0;
        pop_pc_out        = '0;
        do_pop_pc_out     = 1'b0;
        sp_inc1           = 1'b0;
        sp_inc2           = 1'b0;
        sp_dec1           = 1'b0;
        sp_dec2           = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    dmem_addr = base;
                    dmem_we   = wr;
                    dmem_re   = rd;
                    if (rd) mem_data_out = dmem_rdata;
                    if (is32) begin
                        stall_out = 1'b1;
                        state_nxt = BEAT2;
                        // Pushes store high half first so a pop sees low half first.
                        if (wr) dmem_wdata = is_push ? data32[31:16] : data32[15:0];
                    end else begin
                        if (wr) dmem_wdata = data16;
                        sp_dec1 = is_push;
                        sp_inc1 = is_pop;
                        if (is_pop && flags_push_pop_in) begin
                            is_POP_flags_out  = 1'b1;
                            POP_flags_val_out = dmem_rdata[3:0];
                        end
                    end
                end
            end
            BEAT2: begin
                // Inputs are frozen by the stall, so the decode is still valid here.
                state_nxt = IDLE;
                dmem_addr = is_push ? (base - ADDR_W'(1)) : (base + ADDR_W'(1));
                dmem_we   = wr;
                dmem_re   = rd;
                if (wr) dmem_wdata = is_push ? data32[15:0] : data32[31:16];
                if (rd) mem_data_out = dmem_rdata;
                sp_dec2 = is_push;
                sp_inc2 = is_pop;
                if (is_pop) begin
                    do_pop_pc_out = 1'b1;
                    pop_pc_out    = {dmem_rdata, lo_q};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, mem_type_in;
    logic [1:0]  SP_src_in;
    logic        mem_addr_src_in, mem_data_src_in, PC_push_pop_in, flags_push_pop_in, INT_in;
    logic [31:0] PC_in;
    logic [15:0] Rdst1_val_in, Rdst2_val_in, Rdst_val_in;
    logic [15:0] dmem_rdata;
    logic [11:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_we, dmem_re;
    logic [15:0] mem_data_out, Rdst2_val_out;
    logic [3:0]  POP_flags_val_out;
    logic        is_POP_flags_out;
    logic [31:0] pop_pc_out;
    logic        do_pop_pc_out, stall_out;
    logic [11:0] SP_out;
`ifdef STACK_GUARD_EN
    logic        stack_exc_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;

    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_we) begin
            mem[dmem_addr] <= dmem_wdata;
            we_count <= we_count + 1;
        end
    end
    assign dmem_rdata = mem[dmem_addr];

    mem_access_stage dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .mem_type_in       (mem_type_in),
        .SP_src_in         (SP_src_in),
        .mem_addr_src_in   (mem_addr_src_in),
        .mem_data_src_in   (mem_data_src_in),
        .PC_push_pop_in    (PC_push_pop_in),
        .flags_push_pop_in (flags_push_pop_in),
        .INT_in            (INT_in),
        .PC_in             (PC_in),
        .Rdst1_val_in      (Rdst1_val_in),
        .Rdst2_val_in      (Rdst2_val_in),
        .Rdst_val_in       (Rdst_val_in),
        .dmem_rdata        (dmem_rdata),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_we           (dmem_we),
        .dmem_re           (dmem_re),
        .mem_data_out      (mem_data_out),
        .Rdst2_val_out     (Rdst2_val_out),
        .POP_flags_val_out (POP_flags_val_out),
        .is_POP_flags_out  (is_POP_flags_out),
        .pop_pc_out        (pop_pc_out),
        .do_pop_pc_out     (do_pop_pc_out),
        .stall_out         (stall_out),
        .SP_out            (SP_out)
`ifdef STACK_GUARD_EN
        ,
        .stack_exc_out     (stack_exc_out)
`endif
    );

    task automatic clear_inputs();
        mem_read_in = 0; mem_write_in = 0; mem_type_in = 0; SP_src_in = 0;
        mem_addr_src_in = 0; mem_data_src_in = 0; PC_push_pop_in = 0;
        flags_push_pop_in = 0; INT_in = 0; PC_in = 0;
        Rdst1_val_in = 0; Rdst2_val_in = 0; Rdst_val_in = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        Rdst2_val_in = 16'h3C3C;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (SP_out !== 12'hFFF) begin n_fail++; $display("FAIL reset_sp: got %h want fff", SP_out); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        n_checks++; if ({dmem_we, dmem_re, do_pop_pc_out, is_POP_flags_out} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {dmem_we, dmem_re, do_pop_pc_out, is_POP_flags_out}); end
        n_checks++; if ({dmem_addr, dmem_wdata, mem_data_out} !== 44'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {dmem_addr, dmem_wdata, mem_data_out}); end
        n_checks++; if (Rdst2_val_out !== 16'h3C3C) begin n_fail++; $display("FAIL passthru: got %h want 3c3c", Rdst2_val_out); end
        reset = 0;
        Rdst2_val_in = 0;
        step();
    endtask

    task automatic test_push16();
        mem_write_in = 1; SP_src_in = 2'd1; mem_addr_src_in = 1; Rdst_val_in = 16'hABCD;
        #1;
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL push16_stall: got %b want 0", stall_out); end
        n_checks++; if (dmem_addr !== 12'hFFF || dmem_we !== 1'b1) begin n_fail++; $display("FAIL push16_addr: got %h/%b want fff/1", dmem_addr, dmem_we); end
        step(); clear_inputs(); #1;
        n_checks++; if (mem[12'hFFF] !== 16'hABCD) begin n_fail++; $display("FAIL push16_mem: got %h want abcd", mem[12'hFFF]); end
        n_checks++; if (SP_out !== 12'hFFE) begin n_fail++; $display("FAIL push16_sp: got %h want ffe", SP_out); end
    endtask

    task automatic test_push32();
        mem_write_in = 1; SP_src_in = 2'd1; mem_addr_src_in = 1; PC_push_pop_in = 1;
        mem_data_src_in = 1; PC_in = 32'h5000_0123;
        #1;
        n_checks++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL push32_stall0: got %b want 1", stall_out); end
        n_checks++; if (dmem_addr !== 12'hFFE || dmem_wdata !== 16'h5000) begin n_fail++; $display("FAIL push32_beat0: got %h/%h want ffe/5000", dmem_addr, dmem_wdata); end
        step();
        n_checks++; if (mem[12'hFFE] !== 16'h5000) begin n_fail++; $display("FAIL push32_mem_hi: got %h want 5000", mem[12'hFFE]); end
        n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL push32_stall1: got %b want 0", stall_out); end
        n_checks++; if (dmem_addr !== 12'hFFD || dmem_wdata !== 16'h0123 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL push32_beat1: got %h/%h/%b want ffd/0123/1", dmem_addr, dmem_wdata, dmem_we); end
        n_checks++; if (SP_out !== 12'hFFE) begin n_fail++; $display("FAIL push32_sp_mid: got %h want ffe", SP_out); end
        step(); clear_inputs(); #1;
        n_checks++; if (mem[12'hFFD] !== 16'h0123) begin n_fail++; $display("FAIL push32_mem_lo: got %h want 0123", mem[12'hFFD]); end
        n_checks++; if (SP_out !== 12'hFFC) begin n_fail++; $display("FAIL push32_sp: got %h want ffc", SP_out); end
    endtask

    task automatic test_pop32();
        mem_read_in = 1; SP_src_in = 2'd2; mem_addr_src_in = 1; PC_push_pop_in = 1;
        #1;
        n_checks++; if (stall_out !== 1'b1 || do_pop_pc_out !== 1'b0) begin n_fail++; $display("FAIL pop32_beat0: got stall %b pop %b want 1/0", stall_out, do_pop_pc_out); end
        n_checks++; if (dmem_addr !== 12'hFFD || dmem_re !== 1'b1) begin n_fail++; $display("FAIL pop32_addr0: got %h/%b want ffd/1", dmem_addr, dmem_re); end
        step();
        n_checks++; if (do_pop_pc_out !== 1'b1 || pop_pc_out !== 32'h5000_0123) begin n_fail++; $display("FAIL pop32_pc: got %b/%h want 1/50000123", do_pop_pc_out, pop_pc_out); end
        n_checks++; if (dmem_addr !== 12'hFFE) begin n_fail++; $display("FAIL pop32_addr1: got %h want ffe", dmem_addr); end
        step(); clear_inputs(); #1;
        n_checks++; if (SP_out !== 12'hFFE || do_pop_pc_out !== 1'b0) begin n_fail++; $display("FAIL pop32_sp: got %h/%b want ffe/0", SP_out, do_pop_pc_out); end
    endtask

    task automatic test_pop_flags();
        // Put 000A on the stack, then pop it as flags.
        mem_write_in = 1; SP_src_in = 2'd1; mem_addr_src_in = 1; Rdst_val_in = 16'h000A;
        step(); clear_inputs();
        mem_read_in = 1; SP_src_in = 2'd2; mem_addr_src_in = 1; flags_push_pop_in = 1;
        #1;
        n_checks++; if (is_POP_flags_out !== 1'b1 || POP_flags_val_out !== 4'hA) begin n_fail++; $display("FAIL pop_flags: got %b/%h want 1/a", is_POP_flags_out, POP_flags_val_out); end
        n_checks++; if (mem_data_out !== 16'h000A || stall_out !== 1'b0) begin n_fail++; $display("FAIL pop16_data: got %h/%b want 000a/0", mem_data_out, stall_out); end
        step(); clear_inputs(); #1;
        n_checks++; if (SP_out !== 12'hFFE || is_POP_flags_out !== 1'b0) begin n_fail++; $display("FAIL pop16_sp: got %h/%b want ffe/0", SP_out, is_POP_flags_out); end
    endtask

    task automatic test_ldst32();
        mem_write_in = 1; mem_type_in = 1; mem_data_src_in = 1; PC_in = 32'hBEEF_1234;
        Rdst1_val_in = 16'h0010;
        #1;
        n_checks++; if (dmem_addr !== 12'h010 || dmem_wdata !== 16'h1234 || stall_out !== 1'b1) begin n_fail++; $display("FAIL st32_beat0: got %h/%h/%b want 010/1234/1", dmem_addr, dmem_wdata, stall_out); end
        step();
        n_checks++; if (dmem_addr !== 12'h011 || dmem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL st32_beat1: got %h/%h want 011/beef", dmem_addr, dmem_wdata); end
        step(); clear_inputs();
        n_checks++; if (mem[12'h010] !== 16'h1234 || mem[12'h011] !== 16'hBEEF) begin n_fail++; $display("FAIL st32_mem: got %h/%h want 1234/beef", mem[12'h010], mem[12'h011]); end
        mem_read_in = 1; mem_type_in = 1; Rdst1_val_in = 16'h0010;
        #1;
        n_checks++; if (mem_data_out !== 16'h1234 || stall_out !== 1'b1) begin n_fail++; $display("FAIL ld32_lo: got %h/%b want 1234/1", mem_data_out, stall_out); end
        step();
        n_checks++; if (mem_data_out !== 16'hBEEF || do_pop_pc_out !== 1'b0) begin n_fail++; $display("FAIL ld32_hi: got %h/%b want beef/0", mem_data_out, do_pop_pc_out); end
        step(); clear_inputs(); #1;
        n_checks++; if (SP_out !== 12'hFFE) begin n_fail++; $display("FAIL ldst32_sp: got %h want ffe", SP_out); end
    endtask

    task automatic test_write_wins();
        mem_write_in = 1; mem_read_in = 1; Rdst1_val_in = 16'hF020; Rdst_val_in = 16'h5A5A;
        #1;
        n_checks++; if (dmem_we !== 1'b1 || dmem_re !== 1'b0 || mem_data_out !== 16'h0) begin n_fail++; $display("FAIL write_wins: got we %b re %b data %h want 1/0/0", dmem_we, dmem_re, mem_data_out); end
        n_checks++; if (dmem_addr !== 12'h020) begin n_fail++; $display("FAIL addr_trunc: got %h want 020", dmem_addr); end
        step(); clear_inputs();
        mem_read_in = 1; Rdst1_val_in = 16'h0020;
        #1;
        n_checks++; if (mem_data_out !== 16'h5A5A || dmem_re !== 1'b1) begin n_fail++; $display("FAIL ld16: got %h/%b want 5a5a/1", mem_data_out, dmem_re); end
        step(); clear_inputs();
        // SP_src code 3 behaves like "no SP use".
        mem_write_in = 1; SP_src_in = 2'd3; Rdst1_val_in = 16'h0030; Rdst_val_in = 16'h1357;
        #1;
        n_checks++; if (dmem_addr !== 12'h030 || dmem_wdata !== 16'h1357) begin n_fail++; $display("FAIL sp_src3: got %h/%h want 030/1357", dmem_addr, dmem_wdata); end
        step(); clear_inputs(); #1;
        n_checks++; if (SP_out !== 12'hFFE) begin n_fail++; $display("FAIL sp_src3_sp: got %h want ffe", SP_out); end
    endtask

    task automatic test_int();
        INT_in = 1; PC_in = 32'hC0DE_0042; Rdst_val_in = 16'h9999; Rdst1_val_in = 16'h0040;
        #1;
        n_checks++; if (dmem_addr !== 12'hFFE || dmem_wdata !== 16'hC0DE || stall_out !== 1'b1) begin n_fail++; $display("FAIL int_beat0: got %h/%h/%b want ffe/c0de/1", dmem_addr, dmem_wdata, stall_out); end
        step();
        n_checks++; if (dmem_addr !== 12'hFFD || dmem_wdata !== 16'h0042) begin n_fail++; $display("FAIL int_beat1: got %h/%h want ffd/0042", dmem_addr, dmem_wdata); end
        step(); clear_inputs(); #1;
        n_checks++; if (SP_out !== 12'hFFC || mem[12'hFFE] !== 16'hC0DE || mem[12'hFFD] !== 16'h0042) begin n_fail++; $display("FAIL int_result: got sp %h mem %h %h want ffc c0de 0042", SP_out, mem[12'hFFE], mem[12'hFFD]); end
    endtask

    task automatic test_reset_in_beat2();
        int wc;
        mem_write_in = 1; SP_src_in = 2'd1; mem_addr_src_in = 1; PC_push_pop_in = 1;
        mem_data_src_in = 1; PC_in = 32'h1111_2222;
        step();
        wc = we_count;
        reset = 1; clear_inputs();
        #1;
        n_checks++; if (SP_out !== 12'hFFF || stall_out !== 1'b0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_beat2: got sp %h stall %b we %b want fff/0/0", SP_out, stall_out, dmem_we); end
        step();
        reset = 0;
        n_checks++; if (we_count !== wc || mem[12'hFFC] !== 16'h1111) begin n_fail++; $display("FAIL rst_beat2_mem: got writes %0d mem %h want %0d/1111", we_count, mem[12'hFFC], wc); end
        // Next access must start from IDLE: a single-cycle push at FFF.
        mem_write_in = 1; SP_src_in = 2'd1; mem_addr_src_in = 1; Rdst_val_in = 16'h7777;
        #1;
        n_checks++; if (dmem_addr !== 12'hFFF || stall_out !== 1'b0 || dmem_wdata !== 16'h7777) begin n_fail++; $display("FAIL post_rst_push: got %h/%b/%h want fff/0/7777", dmem_addr, stall_out, dmem_wdata); end
        step(); clear_inputs(); #1;
        n_checks++; if (SP_out !== 12'hFFE) begin n_fail++; $display("FAIL post_rst_sp: got %h want ffe", SP_out); end
    endtask

`ifdef STACK_GUARD_EN
    task automatic test_stack_guard();
        reset = 1; clear_inputs();
        step();
        reset = 0;
        n_checks++; if (stack_exc_out !== 1'b0) begin n_fail++; $display("FAIL guard_init: got %b want 0", stack_exc_out); end
        mem_read_in = 1; SP_src_in = 2'd2; mem_addr_src_in = 1;
        #1;
        n_checks++; if (dmem_re !== 1'b0 || stall_out !== 1'b0 || is_POP_flags_out !== 1'b0) begin n_fail++; $display("FAIL guard_suppress: got re %b stall %b want 0/0", dmem_re, stall_out); end
        step(); clear_inputs(); #1;
        n_checks++; if (stack_exc_out !== 1'b1 || SP_out !== 12'hFFF) begin n_fail++; $display("FAIL guard_pop: got exc %b sp %h want 1/fff", stack_exc_out, SP_out); end
        step();
        n_checks++; if (stack_exc_out !== 1'b1) begin n_fail++; $display("FAIL guard_sticky: got %b want 1", stack_exc_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_push16();
        test_push32();
        test_pop32();
        test_pop_flags();
        test_ldst32();
        test_write_wins();
        test_int();
        test_reset_in_beat2();
`ifdef STACK_GUARD_EN
        test_stack_guard();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
